// File: rtl/cordic_fixedpoint_asel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_fixedpoint_asel_pkg
// Brief    : Shared constants, state encoding and theta table for the
//            fixed-point CORDIC angle-selection path.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_fixedpoint_asel_pkg;

  // Number of entries in the theta table and width of each entry.
  localparam int THETA_N = 16;
  localparam int THETA_W = 16;

  // Width of the accepted-step counter (holds 0..16).
  localparam int ITER_W  = 5;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } asel_state_t;

  // atan(2^-i) scaled by 2^15, rounded to nearest. Strictly decreasing, so a
  // lower index always means a larger angle.
  function automatic logic [THETA_W-1:0] theta_lut(input logic [3:0] idx);
    logic [THETA_W-1:0] val;
    case (idx)
      4'd0:    val = 16'd25736;
      4'd1:    val = 16'd15193;
      4'd2:    val = 16'd8027;
      4'd3:    val = 16'd4075;
      4'd4:    val = 16'd2045;
      4'd5:    val = 16'd1024;
      4'd6:    val = 16'd512;
      4'd7:    val = 16'd256;
      4'd8:    val = 16'd128;
      4'd9:    val = 16'd64;
      4'd10:   val = 16'd32;
      4'd11:   val = 16'd16;
      4'd12:   val = 16'd8;
      4'd13:   val = 16'd4;
      4'd14:   val = 16'd2;
      default: val = 16'd1;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_fixedpoint_get_phase_addr_priority_16to4.sv
`default_nettype none
// ============================================================================
// Module   : cordic_fixedpoint_get_phase_addr_priority_16to4
// Brief    : 16-to-4 priority encoder; bit 0 has the highest priority.
//            Returns 0 when no bit is set, so callers needing a "none"
//            indication must OR-reduce the request vector themselves.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_fixedpoint_get_phase_addr_priority_16to4 (
  input  logic [15:0] req,
  output logic [3:0]  addr
);

  // Scan from the lowest-priority bit upward so the lowest set index wins.
  always_comb begin
    addr = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) begin
        addr = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_fixedpoint_asel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_fixedpoint_asel_ctrl
// Brief    : Angle-selection sequencer. Repeatedly picks the largest theta
//            not exceeding |residual|, offers it to the rotation datapath
//            over valid/ready, and updates the residual on acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_fixedpoint_asel_ctrl
  import cordic_fixedpoint_asel_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iZ,
  output logic             oBusy,
  output logic             oStep_valid,
  input  logic             iStep_ready,
  output logic [3:0]       oTheta_addr,
  output logic             oDir,
  output logic [4:0]       oIter,
  output logic             oDone,
  output logic [WIDTH-1:0] oZ_res
);

  asel_state_t       state;
  asel_state_t       state_nxt;
  logic [WIDTH-1:0]  z;
  logic [ITER_W-1:0] iter;
  logic [WIDTH-1:0]  abs_z;
  logic [15:0]       cmp;
  logic [3:0]        enc_addr;
  logic              any_fit;
  logic              at_limit;
  logic              stop;
  logic [WIDTH-1:0]  theta_sel;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // Residual magnitude; the most negative code has no positive twin and
  // saturates to the largest positive value.
  always_comb begin
    abs_z = z;
    if (z[WIDTH-1]) begin
      if (z == MOST_NEG) begin
        abs_z = MOST_POS;
      end else begin
        abs_z = -z;
      end
    end
  end

  // Comparator bank: one bit per table entry that still fits in the residual.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < THETA_N; i++) begin
      cmp[i] = (abs_z >= WIDTH'(theta_lut(4'(i))));
    end
  end

  cordic_fixedpoint_get_phase_addr_priority_16to4 u_prio (
    .req  (cmp),
    .addr (enc_addr)
  );

  // The encoder reports 0 for an empty vector, so "nothing fits" comes from
  // the OR-reduction rather than the encoded address.
  assign any_fit   = |cmp;
  assign at_limit  = (iter == ITER_W'(MAX_ITER));
  assign stop      = !any_fit || at_limit;
  assign theta_sel = WIDTH'(theta_lut(oTheta_addr));
  assign oIter     = iter;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          state_nxt = ST_SEL;
        end
      end
      ST_SEL: begin
        state_nxt = stop ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (iStep_ready) begin
          state_nxt = ST_SEL;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Residual, step counter and registered outputs, updated alongside the
  // state transitions so every output is a flop.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      z           <= '0;
      iter        <= '0;
      oBusy       <= 1'b0;
      oStep_valid <= 1'b0;
      oTheta_addr <= 4'd0;
      oDir        <= 1'b0;
      oDone       <= 1'b0;
      oZ_res      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            z     <= iZ;
            iter  <= '0;
            oBusy <= 1'b1;
          end
        end
        ST_SEL: begin
          if (stop) begin
            oDone  <= 1'b1;
            oZ_res <= z;
          end else begin
            oTheta_addr <= enc_addr;
            oDir        <= z[WIDTH-1];
            oStep_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (iStep_ready) begin
            z           <= oDir ? (z + theta_sel) : (z - theta_sel);
            iter        <= iter + 1'b1;
            oStep_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
        default: begin
          oDone <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_fixedpoint_asel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_fixedpoint_asel_ctrl
// Brief    : Directed self-checking bench for the angle-selection sequencer.
//            A second instance with a one-step limit covers early stop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_fixedpoint_asel_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [15:0] z_in;
  logic        ready;
  logic        sel;

  logic        busy1, valid1, dir1, done1;
  logic [3:0]  addr1;
  logic [4:0]  iter1;
  logic [15:0] zres1;
  logic        busy2, valid2, dir2, done2;
  logic [3:0]  addr2;
  logic [4:0]  iter2;
  logic [15:0] zres2;

  logic        busy_m, valid_m, dir_m, done_m;
  logic [3:0]  addr_m;
  logic [4:0]  iter_m;
  logic [15:0] zres_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_fixedpoint_asel_ctrl #(.WIDTH(16), .MAX_ITER(16)) dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1), .iZ(z_in),
    .oBusy(busy1), .oStep_valid(valid1), .iStep_ready(ready),
    .oTheta_addr(addr1), .oDir(dir1), .oIter(iter1),
    .oDone(done1), .oZ_res(zres1)
  );

  cordic_fixedpoint_asel_ctrl #(.WIDTH(16), .MAX_ITER(1)) dut2 (
    .iClk(clk), .iRst(rst), .iStart(start2), .iZ(z_in),
    .oBusy(busy2), .oStep_valid(valid2), .iStep_ready(ready),
    .oTheta_addr(addr2), .oDir(dir2), .oIter(iter2),
    .oDone(done2), .oZ_res(zres2)
  );

  assign busy_m  = sel ? busy2  : busy1;
  assign valid_m = sel ? valid2 : valid1;
  assign dir_m   = sel ? dir2   : dir1;
  assign done_m  = sel ? done2  : done1;
  assign addr_m  = sel ? addr2  : addr1;
  assign iter_m  = sel ? iter2  : iter1;
  assign zres_m  = sel ? zres2  : zres1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},  busy_m,  0);
    check_val({tag, "_valid"}, valid_m, 0);
    check_val({tag, "_addr"},  addr_m,  0);
    check_val({tag, "_dir"},   dir_m,   0);
    check_val({tag, "_iter"},  iter_m,  0);
    check_val({tag, "_done"},  done_m,  0);
    check_val({tag, "_zres"},  zres_m,  0);
  endtask

  // One operation with ready held high. Negedge k after the start edge shows
  // what the DUT registered at edge T+k-1, i.e. its value "at T+k".
  task automatic do_op(input logic sel_i, input logic [15:0] zv, input int n_steps,
                       input logic [3:0] a0, input logic d0,
                       input logic [15:0] res, input logic [4:0] it);
    bit first;
    bit finished;
    sel   = sel_i;
    ready = 1'b1;
    @(negedge clk);
    z_in = zv;
    if (sel_i) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    check_val("busy_t1", busy_m, 1);
    first    = 1'b0;
    finished = 1'b0;
    for (int k = 1; k <= 80 && !finished; k++) begin
      if (k > 1) @(negedge clk);
      if (valid_m && !first) begin
        first = 1'b1;
        check_val("first_step_cyc", k, 2);
        check_val("addr0", addr_m, a0);
        check_val("dir0", dir_m, d0);
      end
      if (done_m) begin
        finished = 1'b1;
        check_val("done_cyc", k, 2 + 2 * n_steps);
        check_val("zres", zres_m, res);
        check_val("iter", iter_m, it);
        if (n_steps == 0) check_val("no_step", first, 0);
        // start raised while in DONE must not launch a new operation
        if (sel_i) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        check_val("done_pulse", done_m, 0);
        check_val("busy_after", busy_m, 0);
        @(negedge clk);
        check_val("start_ignored", busy_m, 0);
      end
    end
    check_val("op_timeout", finished, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit finished;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; z_in = '0; ready = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    do_op(1'b0, 16'd4075, 1, 4'd3, 1'b0, 16'd0, 5'd1);
    do_op(1'b0, -16'sd25736, 1, 4'd0, 1'b1, 16'd0, 5'd1);
    do_op(1'b0, 16'd0, 0, 4'd0, 1'b0, 16'd0, 5'd0);
    do_op(1'b0, -16'sd100, 3, 4'd9, 1'b1, 16'd0, 5'd3);
    do_op(1'b0, 16'h8000, 7, 4'd0, 1'b1, 16'd0, 5'd7);

    // Back-pressure: ready low while the step is offered.
    sel = 1'b0; ready = 1'b0;
    @(negedge clk);
    z_in = 16'd8027; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      check_val("bp_valid", valid_m, 1);
      check_val("bp_addr", addr_m, 2);
      check_val("bp_dir", dir_m, 0);
      check_val("bp_iter", iter_m, 0);
    end
    ready = 1'b1;
    @(negedge clk);
    check_val("bp_accept_valid", valid_m, 0);
    check_val("bp_accept_iter", iter_m, 1);
    @(negedge clk);
    check_val("bp_done", done_m, 1);
    check_val("bp_zres", zres_m, 0);
    @(negedge clk);
    check_val("bp_busy_after", busy_m, 0);

    // Iteration limit of one on the second instance.
    do_op(1'b1, 16'd27781, 1, 4'd0, 1'b0, 16'd2045, 5'd1);

    // Asynchronous reset while a step is offered.
    sel = 1'b0; ready = 1'b0;
    @(negedge clk);
    z_in = 16'd8027; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check_val("pre_rst_valid", valid_m, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    finished = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_m || valid_m) finished = 1'b1;
    end
    check_val("no_done_after_rst", finished, 0);
    do_op(1'b0, 16'd27781, 2, 4'd0, 1'b0, 16'd0, 5'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_fixedpoint_asel_ctrl.md
# cordic_fixedpoint_asel_ctrl

Angle-selection sequencer for the fixed-point CORDIC ASEL path. It accepts a target angle, and on each step compares the residual magnitude against the 16-entry theta table. It picks the largest table angle not exceeding the residual through a 16-to-4 priority encode, then issues that theta address and rotation direction to the rotation datapath over a valid/ready handshake. After each accepted step it updates the residual, and it stops when no entry fits or the iteration limit is reached.

## Interface
Parameters:
- WIDTH, 16, width of signed two's-complement angle and residual
- MAX_ITER, 16, maximum issued steps per operation (1..16)

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  reset; one clock; reset is asynchronous and active-high
- iStart  in  1  start pulse; sampled only in IDLE
- iZ  in  WIDTH  signed target angle, sampled with iStart
- oBusy  out  1  high in any state other than IDLE
- oStep_valid  out  1  step offer to rotation datapath
- iStep_ready  in  1  datapath accepts step when high with oStep_valid
- oTheta_addr  out  4  selected theta table index
- oDir  out  1  0: subtract theta (residual ≥ 0); 1: add theta (residual < 0)
- oIter  out  5  number of steps accepted so far in current operation
- oDone  out  1  one-cycle completion pulse
- oZ_res  out  WIDTH  final residual; valid while oDone high, then held

## Operation
- States: IDLE, SEL, ISSUE, DONE.
- IDLE: on iStart, latch z <= iZ, clear iter to 0, go to SEL. iStart is ignored in every other state.
- SEL:
  - abs = |z|; the most negative value saturates to the maximum positive value.
  - Comparator vector: cmp[i] = (abs >= THETA[i]), i = 0..15.
  - THETA is strictly decreasing with index, so index 0 has the highest priority.
  - If cmp == 0 or iter == MAX_ITER, go to DONE.
  - Otherwise register oTheta_addr = lowest set index and oDir = sign(z), then go to ISSUE.
- ISSUE:
  - oStep_valid = 1; oTheta_addr and oDir are held stable.
  - On iStep_ready = 1: z <= oDir ? z + THETA[addr] : z − THETA[addr] (WIDTH-bit wrap; no saturation), iter++, go to SEL.
  - While iStep_ready = 0: hold the state; all outputs stay stable.
- DONE: oDone = 1, oZ_res = z, go to IDLE next cycle.
- The encoder output alone cannot tell "index 0" from "no bit set". Termination therefore uses the OR-reduction of cmp, not the encoder output.

## Timing
- All outputs are registered. Reset values: oBusy 0, oStep_valid 0, oTheta_addr 0, oDir 0, oIter 0, oDone 0, oZ_res 0; state IDLE.
- iStart accepted at edge T:
  - oBusy = 1 from T+1.
  - First oStep_valid at T+2.
- With iStep_ready held high, one step takes 2 cycles (ISSUE then SEL).
  - n steps: oDone at T+2+2n when terminated by cmp == 0.
  - Same timing when terminated by the limit (n == MAX_ITER).
- Zero-step case (iZ = 0): oDone at T+2, oIter = 0.
- oDone is high for exactly one cycle; oBusy = 0 in the cycle after oDone.
- iRst asserted mid-operation: all state and outputs clear asynchronously. An offered step is dropped, and no oDone is produced.
- iStart coincident with oDone: ignored (state is DONE, not IDLE).

## Structure
- Shared package cordic_fixedpoint_asel_pkg holds:
  - THETA table: 16 × WIDTH, strictly decreasing.
  - State encoding enum.
  - Constant for oIter width.
- The comparator bank is local combinational logic.
- Sub-module: the team's existing 16-to-4 priority encoder, cordic_fixedpoint_get_phase_addr_priority_16to4, instantiated once.
  - Its input bit order is passed unchanged: bit i = cmp[i].

## Test plan
- iZ = THETA[3], ready high -> one step (addr 3, dir 0) at T+2; oDone at T+4 with oZ_res = 0, oIter = 1.
- iZ = −THETA[0] -> step addr 0, dir 1; oZ_res = 0.
- iZ = 0 -> no oStep_valid; oDone at T+2, oIter = 0.
- iZ = THETA[2], iStep_ready low for 5 cycles -> oStep_valid and addr 2 stable throughout; update happens only on the ready cycle.
- MAX_ITER = 1, iZ = THETA[0] + THETA[4] -> single step addr 0; oDone with oZ_res = THETA[4], oIter = 1.
- iRst pulsed during ISSUE -> all outputs 0 immediately, state IDLE; a new iStart then behaves normally.
